// File: rtl/rgb_arbiter_if.sv
// Bundle of client handshake and converter drive signals for rgb_arbiter.
// master = client/converter side, slave = arbiter side.
interface rgb_arbiter_if;
  logic       req_a;
  logic [2:0] colour_a;
  logic       req_b;
  logic [2:0] colour_b;
  logic       gnt_a;
  logic       gnt_b;
  logic       done_a;
  logic       done_b;
  logic       conv_enable;
  logic [2:0] conv_colour;
  logic       busy;

  modport master (
    output req_a, colour_a, req_b, colour_b,
    input  gnt_a, gnt_b, done_a, done_b, conv_enable, conv_colour, busy
  );

  modport slave (
    input  req_a, colour_a, req_b, colour_b,
    output gnt_a, gnt_b, done_a, done_b, conv_enable, conv_colour, busy
  );
endinterface

// File: rtl/rgb_arbiter.sv
// Round-robin, non-preemptive owner of a shared RGB converter for two clients.
// Optional RGB_ARB_IDLE_CYCLE_EN: converter steps through colours 001..111 while idle.
module rgb_arbiter #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  rgb_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_A = 2'b01,
    SERVE_B = 2'b10
  } state_e;

  typedef enum logic {
    CLIENT_A = 1'b0,
    CLIENT_B = 1'b1
  } client_e;

  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(DWELL - 32'sd1);

  state_e           state_r, state_s;
  client_e          last_r, last_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             gnt_a_r, gnt_a_s;
  logic             gnt_b_r, gnt_b_s;
  logic             done_a_r, done_a_s;
  logic             done_b_r, done_b_s;
  logic             busy_r, busy_s;
  logic             en_r, en_s;
  logic [2:0]       colour_r, colour_s;

`ifdef RGB_ARB_IDLE_CYCLE_EN
  logic [2:0]       step_r, step_s;
  logic [CNT_W-1:0] idle_cnt_r, idle_cnt_s;

  // Idle colour walk wraps 111 -> 001, never emitting 000.
  function automatic logic [2:0] next_step(input logic [2:0] s);
    if (s == 3'b111) begin
      return 3'b001;
    end else begin
      return s + 3'b001;
    end
  endfunction
`endif

  // Next-state and next-output decode; outputs are registered from these.
  always_comb begin
    state_s  = state_r;
    last_s   = last_r;
    cnt_s    = cnt_r;
    gnt_a_s  = 1'b0;
    gnt_b_s  = 1'b0;
    done_a_s = 1'b0;
    done_b_s = 1'b0;
    busy_s   = 1'b0;
    en_s     = 1'b0;
    colour_s = 3'b000;
`ifdef RGB_ARB_IDLE_CYCLE_EN
    step_s     = step_r;
    idle_cnt_s = idle_cnt_r;
`endif
    case (state_r)
      IDLE: begin
        // A wins when alone, or on a tie when B was served last.
        if (bus.req_a && (!bus.req_b || (last_r == CLIENT_B))) begin
          state_s  = SERVE_A;
          last_s   = CLIENT_A;
          cnt_s    = LOAD;
          gnt_a_s  = 1'b1;
          done_a_s = (LOAD == ZERO);
          busy_s   = 1'b1;
          en_s     = 1'b1;
          colour_s = bus.colour_a;
        end else if (bus.req_b) begin
          state_s  = SERVE_B;
          last_s   = CLIENT_B;
          cnt_s    = LOAD;
          gnt_b_s  = 1'b1;
          done_b_s = (LOAD == ZERO);
          busy_s   = 1'b1;
          en_s     = 1'b1;
          colour_s = bus.colour_b;
        end else begin
          state_s = IDLE;
        end
      end
      SERVE_A, SERVE_B: begin
        if (cnt_r == ZERO) begin
          state_s = IDLE;
          cnt_s   = ZERO;
        end else begin
          cnt_s    = cnt_r - ONE;
          busy_s   = 1'b1;
          en_s     = 1'b1;
          colour_s = colour_r;
          if (state_r == SERVE_A) begin
            gnt_a_s  = 1'b1;
            done_a_s = (cnt_r == ONE);
          end else begin
            gnt_b_s  = 1'b1;
            done_b_s = (cnt_r == ONE);
          end
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = ZERO;
      end
    endcase
`ifdef RGB_ARB_IDLE_CYCLE_EN
    // Every idle cycle shows the current step; position is frozen during grants.
    if (state_s == IDLE) begin
      en_s     = 1'b1;
      colour_s = step_r;
      if (idle_cnt_r == LOAD) begin
        idle_cnt_s = ZERO;
        step_s     = next_step(step_r);
      end else begin
        idle_cnt_s = idle_cnt_r + ONE;
        step_s     = step_r;
      end
    end else begin
      idle_cnt_s = idle_cnt_r;
      step_s     = step_r;
    end
`endif
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      last_r   <= CLIENT_B;
      cnt_r    <= ZERO;
      gnt_a_r  <= 1'b0;
      gnt_b_r  <= 1'b0;
      done_a_r <= 1'b0;
      done_b_r <= 1'b0;
      busy_r   <= 1'b0;
      en_r     <= 1'b0;
      colour_r <= 3'b000;
    end else begin
      state_r  <= state_s;
      last_r   <= last_s;
      cnt_r    <= cnt_s;
      gnt_a_r  <= gnt_a_s;
      gnt_b_r  <= gnt_b_s;
      done_a_r <= done_a_s;
      done_b_r <= done_b_s;
      busy_r   <= busy_s;
      en_r     <= en_s;
      colour_r <= colour_s;
    end
  end

`ifdef RGB_ARB_IDLE_CYCLE_EN
  // Idle colour-walk position and its dwell counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_r     <= 3'b001;
      idle_cnt_r <= ZERO;
    end else begin
      step_r     <= step_s;
      idle_cnt_r <= idle_cnt_s;
    end
  end
`endif

  assign bus.gnt_a       = gnt_a_r;
  assign bus.gnt_b       = gnt_b_r;
  assign bus.done_a      = done_a_r;
  assign bus.done_b      = done_b_r;
  assign bus.busy        = busy_r;
  assign bus.conv_enable = en_r;
  assign bus.conv_colour = colour_r;

endmodule
